// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter that shares one registered AND/OR/NAND/NOR unit among
// NUM_REQ requesters. One transaction at a time: grant, issue, capture, respond.
module logic_unit_arbiter #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_A,
   input  logic [NUM_REQ*WIDTH-1:0] req_B,
   input  logic [NUM_REQ*2-1:0]     req_OP,
   output logic [WIDTH-1:0]         alu_A,
   output logic [WIDTH-1:0]         alu_B,
   output logic [1:0]               alu_OP,
   output logic                     alu_enable,
   input  logic [WIDTH-1:0]         alu_out,
   input  logic                     alu_flag,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [WIDTH-1:0]         resp_data,
   output logic [ID_W-1:0]          resp_id,
   output logic                     resp_err,
   output logic                     busy,
   output logic [15:0]              ops_done
);

   typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [1:0]        op_q, op_d;
   logic [WIDTH-1:0]  resp_data_q, resp_data_d;
   logic [ID_W-1:0]   resp_id_q, resp_id_d;
   logic              resp_err_q, resp_err_d;
   logic [15:0]       ops_done_q, ops_done_d;

   logic              found;
   logic [ID_W-1:0]   win;
   logic [31:0]       idx;
   logic [ID_W-1:0]   cand;

   // Winner search: first valid requester at or above the pointer, wrapping around
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx  = (32'(ptr_q) + k) % NUM_REQ;
         cand = idx[ID_W-1:0];
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         id_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         resp_data_q <= '0;
         resp_id_q   <= '0;
         resp_err_q  <= 1'b0;
         ops_done_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         resp_data_q <= resp_data_d;
         resp_id_q   <= resp_id_d;
         resp_err_q  <= resp_err_d;
         ops_done_q  <= ops_done_d;
      end
   end

   // Next-state and register updates per state
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      resp_data_d = resp_data_q;
      resp_id_d   = resp_id_q;
      resp_err_d  = resp_err_q;
      ops_done_d  = ops_done_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               a_d     = req_A[win*WIDTH +: WIDTH];
               b_d     = req_B[win*WIDTH +: WIDTH];
               op_d    = req_OP[win*2 +: 2];
               id_d    = win;
               state_d = StIssue;
            end
         end
         StIssue: state_d = StCapture;
         StCapture: begin
            resp_data_d = alu_out;
            resp_err_d  = ~alu_flag;
            resp_id_d   = id_q;
            state_d     = StResp;
         end
         StResp: begin
            if (resp_ready) begin
               state_d = StIdle;
               // Pointer moves only on completion, to the requester after the one served
               ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
               if (ops_done_q != 16'hFFFF) begin
                  ops_done_d = ops_done_q + 16'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from state and registers
   always_comb begin
      req_ready = '0;
      if (state_q == StIdle && found) begin
         req_ready[win] = 1'b1;
      end
      alu_A      = a_q;
      alu_B      = b_q;
      alu_OP     = op_q;
      alu_enable = (state_q == StIssue);
      resp_valid = (state_q == StResp);
      resp_data  = resp_data_q;
      resp_id    = resp_id_q;
      resp_err   = resp_err_q;
      busy       = (state_q != StIdle);
      ops_done   = ops_done_q;
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter with a behavioural shared unit and
// a scoreboard filled at grant time and drained at response time.
module tb_logic_unit_arbiter;
   localparam int WIDTH   = 16;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                     CLK = 1'b0;
   logic                     RST = 1'b1;
   logic [NUM_REQ-1:0]       req_valid = '0;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_A = '0;
   logic [NUM_REQ*WIDTH-1:0] req_B = '0;
   logic [NUM_REQ*2-1:0]     req_OP = '0;
   logic [WIDTH-1:0]         alu_A, alu_B;
   logic [1:0]               alu_OP;
   logic                     alu_enable;
   logic [WIDTH-1:0]         alu_out;
   logic                     alu_flag;
   logic                     resp_valid;
   logic                     resp_ready = 1'b1;
   logic [WIDTH-1:0]         resp_data;
   logic [ID_W-1:0]          resp_id;
   logic                     resp_err;
   logic                     busy;
   logic [15:0]              ops_done;

   logic err_inject = 1'b0;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [WIDTH-1:0] data;
      logic             err;
   } exp_t;

   exp_t exp_q[$];
   int   grant_q[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   always #5 CLK = ~CLK;

   logic_unit_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_A(req_A), .req_B(req_B), .req_OP(req_OP),
      .alu_A(alu_A), .alu_B(alu_B), .alu_OP(alu_OP), .alu_enable(alu_enable),
      .alu_out(alu_out), .alu_flag(alu_flag),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err),
      .busy(busy), .ops_done(ops_done)
   );

   function automatic logic [WIDTH-1:0] op_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [1:0] op);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return ~(a & b);
         default: return ~(a | b);
      endcase
   endfunction

   // Shared logic unit: one-cycle registered result, flag set on valid results
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         alu_out  <= '0;
         alu_flag <= 1'b0;
      end else if (alu_enable) begin
         alu_out  <= op_fn(alu_A, alu_B, alu_OP);
         alu_flag <= !err_inject;
      end
   end

   // Grant monitor: legality check and scoreboard push
   always @(negedge CLK) begin
      if (!RST && req_ready != '0) begin
         int   g;
         exp_t e;
         g = 0;
         for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
         total_cnt++;
         if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0 || busy)
            $display("FAIL grant_legal req_ready=%b req_valid=%b busy=%b want onehot subset idle",
                     req_ready, req_valid, busy);
         else pass_cnt++;
         e.id   = ID_W'(g);
         e.data = op_fn(req_A[g*WIDTH +: WIDTH], req_B[g*WIDTH +: WIDTH], req_OP[g*2 +: 2]);
         e.err  = err_inject;
         exp_q.push_back(e);
         grant_q.push_back(g);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_resp(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (resp_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset();
      RST       = 1'b1;
      req_valid = '0;
      tick();
      exp_q.delete();
      grant_q.delete();
      RST = 1'b0;
      tick();
   endtask

   task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [1:0] op);
      req_A[i*WIDTH +: WIDTH] = a;
      req_B[i*WIDTH +: WIDTH] = b;
      req_OP[i*2 +: 2]        = op;
   endtask

   task automatic test_reset();
      bit ok;
      tick();
      total_cnt++;
      if ({req_ready, alu_enable, resp_valid, busy} !== '0 || ops_done !== 16'h0)
         $display("FAIL reset_hold got rdy=%b en=%b rv=%b busy=%b ops=%h want all 0",
                  req_ready, alu_enable, resp_valid, busy, ops_done);
      else pass_cnt++;
      RST = 1'b0;
      tick();
      set_req(0, 16'hFFFF, 16'h1234, 2'b00);
      req_valid  = 4'b0001;
      resp_ready = 1'b0;
      wait_resp(ok);
      req_valid = '0;
      total_cnt++;
      if (!ok || resp_data !== 16'h1234) $display("FAIL pre_reset_resp got ok=%0d data=%h want 1 1234", ok, resp_data);
      else pass_cnt++;
      #2 RST = 1'b1;
      #1;
      total_cnt++;
      if ({req_ready, alu_enable, resp_valid, busy, resp_err} !== '0)
         $display("FAIL async_reset_ctl got rdy=%b en=%b rv=%b busy=%b err=%b want 0",
                  req_ready, alu_enable, resp_valid, busy, resp_err);
      else pass_cnt++;
      total_cnt++;
      if (resp_data !== '0 || resp_id !== '0 || ops_done !== '0 || alu_A !== '0 || alu_B !== '0)
         $display("FAIL async_reset_data got data=%h id=%0d ops=%h A=%h B=%h want 0",
                  resp_data, resp_id, ops_done, alu_A, alu_B);
      else pass_cnt++;
      tick();
      exp_q.delete();
      grant_q.delete();
      RST        = 1'b0;
      resp_ready = 1'b1;
      repeat (3) tick();
      total_cnt++;
      if (busy !== 1'b0 || resp_valid !== 1'b0 || grant_q.size() != 0)
         $display("FAIL post_reset_idle got busy=%b rv=%b grants=%0d want 0 0 0",
                  busy, resp_valid, grant_q.size());
      else pass_cnt++;
   endtask

   task automatic test_single();
      exp_t e;
      set_req(2, 16'hF0F0, 16'h0FF0, 2'b00);
      req_valid = 4'b0100;
      #1;
      total_cnt++;
      if (req_ready !== 4'b0100 || busy !== 1'b0)
         $display("FAIL single_grant got rdy=%b busy=%b want 0100 0", req_ready, busy);
      else pass_cnt++;
      tick();
      req_valid = '0;
      total_cnt++;
      if (alu_enable !== 1'b1 || busy !== 1'b1 || alu_A !== 16'hF0F0 || alu_B !== 16'h0FF0 || alu_OP !== 2'b00)
         $display("FAIL single_issue got en=%b busy=%b A=%h B=%h op=%b want 1 1 f0f0 0ff0 00",
                  alu_enable, busy, alu_A, alu_B, alu_OP);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (alu_enable !== 1'b0 || resp_valid !== 1'b0)
         $display("FAIL single_capture got en=%b rv=%b want 0 0", alu_enable, resp_valid);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (resp_valid !== 1'b1 || resp_data !== 16'h00F0 || resp_id !== 2'd2 || resp_err !== 1'b0)
         $display("FAIL single_resp got rv=%b data=%h id=%0d err=%b want 1 00f0 2 0",
                  resp_valid, resp_data, resp_id, resp_err);
      else pass_cnt++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (resp_data !== e.data || resp_id !== e.id)
            $display("FAIL single_sb got data=%h id=%0d want %h %0d", resp_data, resp_id, e.data, e.id);
         else pass_cnt++;
      end
      tick();
      total_cnt++;
      if (ops_done !== 16'd1 || busy !== 1'b0 || resp_valid !== 1'b0)
         $display("FAIL single_done got ops=%0d busy=%b rv=%b want 1 0 0", ops_done, busy, resp_valid);
      else pass_cnt++;
   endtask

   task automatic test_round_robin();
      exp_t e;
      int   n = 0;
      do_reset();
      for (int i = 0; i < NUM_REQ; i++)
         set_req(i, 16'h3C5A + 16'(i * 16'h1111), 16'hA5C3 ^ 16'(i * 16'h0F0F), 2'(i));
      resp_ready = 1'b1;
      req_valid  = 4'b1111;
      for (int c = 0; c < 60 && n < 5; c++) begin
         tick();
         if (resp_valid) begin
            n++;
            if (n == 5) req_valid = '0;
            total_cnt++;
            if (exp_q.size() == 0) $display("FAIL rr_sb_empty got 0 entries want 1");
            else begin
               e = exp_q.pop_front();
               if (resp_id !== e.id || resp_data !== e.data || resp_err !== e.err)
                  $display("FAIL rr_resp got id=%0d data=%h err=%b want %0d %h %b",
                           resp_id, resp_data, resp_err, e.id, e.data, e.err);
               else pass_cnt++;
            end
         end
      end
      tick();
      total_cnt++;
      if (n != 5 || grant_q.size() != 5) $display("FAIL rr_count got resp=%0d grants=%0d want 5 5", n, grant_q.size());
      else pass_cnt++;
      for (int k = 0; k < grant_q.size(); k++) begin
         total_cnt++;
         if (grant_q[k] != k % NUM_REQ) $display("FAIL rr_order[%0d] got %0d want %0d", k, grant_q[k], k % NUM_REQ);
         else pass_cnt++;
      end
      total_cnt++;
      if (ops_done !== 16'd5) $display("FAIL rr_ops got %0d want 5", ops_done);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      bit              ok;
      exp_t            e;
      logic [WIDTH-1:0] d;
      logic [ID_W-1:0]  id;
      set_req(1, 16'h1357, 16'h2468, 2'b01);
      resp_ready = 1'b0;
      req_valid  = 4'b0010;
      wait_resp(ok);
      req_valid = 4'b1101;
      d  = resp_data;
      id = resp_id;
      total_cnt++;
      if (!ok || d !== 16'h377F || id !== 2'd1) $display("FAIL bp_first got ok=%0d data=%h id=%0d want 1 377f 1", ok, d, id);
      else pass_cnt++;
      for (int c = 0; c < 5; c++) begin
         tick();
         total_cnt++;
         if (resp_valid !== 1'b1 || resp_data !== d || resp_id !== id || busy !== 1'b1 || req_ready !== '0)
            $display("FAIL bp_hold[%0d] got rv=%b data=%h id=%0d busy=%b rdy=%b want 1 %h %0d 1 0000",
                     c, resp_valid, resp_data, resp_id, busy, req_ready, d, id);
         else pass_cnt++;
      end
      resp_ready = 1'b1;
      tick();
      req_valid = '0;
      total_cnt++;
      if (busy !== 1'b0 || resp_valid !== 1'b0) $display("FAIL bp_release got busy=%b rv=%b want 0 0", busy, resp_valid);
      else pass_cnt++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (d !== e.data || id !== e.id) $display("FAIL bp_sb got data=%h id=%0d want %h %0d", d, id, e.data, e.id);
         else pass_cnt++;
      end
   endtask

   task automatic test_error();
      bit          ok;
      exp_t        e;
      logic [15:0] od;
      od         = ops_done;
      err_inject = 1'b1;
      set_req(3, 16'h0000, 16'h0000, 2'b11);
      req_valid = 4'b1000;
      wait_resp(ok);
      req_valid = '0;
      total_cnt++;
      if (!ok || resp_err !== 1'b1 || resp_data !== 16'hFFFF || resp_id !== 2'd3)
         $display("FAIL err_resp got ok=%0d err=%b data=%h id=%0d want 1 1 ffff 3", ok, resp_err, resp_data, resp_id);
      else pass_cnt++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (resp_err !== e.err || resp_data !== e.data) $display("FAIL err_sb got err=%b data=%h want %b %h", resp_err, resp_data, e.err, e.data);
         else pass_cnt++;
      end
      tick();
      err_inject = 1'b0;
      total_cnt++;
      if (ops_done !== od + 16'd1) $display("FAIL err_ops got %0d want %0d", ops_done, od + 16'd1);
      else pass_cnt++;
   endtask

   task automatic test_sat_withdraw();
      bit   ok;
      exp_t e;
      grant_q.delete();
      force dut.ops_done_d = 16'hFFFF;
      tick();
      release dut.ops_done_d;
      #1;
      total_cnt++;
      if (ops_done !== 16'hFFFF) $display("FAIL sat_preload got %h want ffff", ops_done);
      else pass_cnt++;
      set_req(0, 16'h00FF, 16'h0F0F, 2'b10);
      set_req(2, 16'hAAAA, 16'h5555, 2'b01);
      req_valid = 4'b0011;
      tick();
      req_valid = 4'b0101;
      for (int r = 0; r < 2; r++) begin
         wait_resp(ok);
         if (r == 1) req_valid = '0;
         total_cnt++;
         if (!ok || exp_q.size() == 0) $display("FAIL sw_resp[%0d] got ok=%0d sb=%0d want 1 1", r, ok, exp_q.size());
         else begin
            e = exp_q.pop_front();
            if (resp_id !== e.id || resp_data !== e.data) $display("FAIL sw_resp[%0d] got id=%0d data=%h want %0d %h", r, resp_id, resp_data, e.id, e.data);
            else pass_cnt++;
         end
         tick();
         total_cnt++;
         if (ops_done !== 16'hFFFF) $display("FAIL sat_hold[%0d] got %h want ffff", r, ops_done);
         else pass_cnt++;
      end
      total_cnt++;
      if (grant_q.size() != 2 || grant_q[0] != 0 || grant_q[1] != 2)
         $display("FAIL withdraw_order got n=%0d g0=%0d g1=%0d want 2 0 2", grant_q.size(),
                  grant_q.size() > 0 ? grant_q[0] : -1, grant_q.size() > 1 ? grant_q[1] : -1);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_error();
      test_sat_withdraw();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Round-robin controller that shares one registered logic unit among NUM_REQ requesters.
- The shared unit is an AND/OR/NAND/NOR block: 2-bit OP, active-high enable, one-cycle registered output, and a flag set on valid results.
- The block accepts one request at a time, sequences the unit's operand/OP/enable inputs, captures the result, and returns it with the requester ID over a valid/ready response channel.
- Sits between the datapath clients and the single shared logic unit instance.

Parameters:
- WIDTH, 16, operand and result width; must equal the logic unit in/out width.
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, requester ID width; must equal ceil(log2(NUM_REQ)).

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept strobe; at most one bit high.
- req_A  input  NUM_REQ*WIDTH  flattened operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_B  input  NUM_REQ*WIDTH  flattened operand B, same packing as req_A.
- req_OP  input  NUM_REQ*2  flattened opcodes: 00 AND, 01 OR, 10 NAND, 11 NOR.
- alu_A  output  WIDTH  operand A to the shared unit.
- alu_B  output  WIDTH  operand B to the shared unit.
- alu_OP  output  2  opcode to the shared unit.
- alu_enable  output  1  enable to the shared unit.
- alu_out  input  WIDTH  registered result from the shared unit.
- alu_flag  input  1  registered valid flag from the shared unit.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response accept.
- resp_data  output  WIDTH  captured result.
- resp_id  output  ID_W  index of the requester served.
- resp_err  output  1  set when alu_flag was 0 at capture.
- busy  output  1  high in any state other than IDLE.
- ops_done  output  16  count of completed responses; saturates at 16'hFFFF.

Behaviour:
- Reset (RST=1, asynchronous):
  - State returns to IDLE; round-robin pointer = 0.
  - All latched operands, resp_data, resp_id, resp_err and ops_done = 0.
  - req_ready, alu_enable, resp_valid and busy = 0.
  - Reset mid-transaction drops that transaction silently; no response is issued.
- State machine, four states:
  - IDLE: if any req_valid bit is set, select winner g by scanning from the pointer upward with wrap. req_ready[g]=1 combinationally in this cycle. On the edge, latch req_A/B/OP slice g and g, then go to ISSUE. With no req_valid, stay in IDLE with req_ready=0.
  - ISSUE: alu_enable=1 for exactly this one cycle; go to CAPTURE.
  - CAPTURE: alu_out and alu_flag are valid this cycle. Register resp_data=alu_out, resp_err=~alu_flag, resp_id=g; go to RESP.
  - RESP: resp_valid=1; resp_data, resp_id and resp_err are held stable.
    - On resp_valid&&resp_ready: go to IDLE, pointer=(g+1) mod NUM_REQ, ops_done increments (saturating).
    - resp_valid stays high until accepted; there is no timeout.
- Unit inputs: alu_A, alu_B and alu_OP are driven from the latched registers at all times; alu_enable is low outside ISSUE.
- Latency and throughput:
  - Accept (IDLE cycle, cycle 0) to resp_valid is 3 cycles (RESP entered at cycle 3).
  - Best-case throughput is one operation per 4 cycles.
- Requester obligations: hold req_valid and operands stable until req_ready. Deasserting req_valid before grant is legal; that requester is simply skipped.
- Fairness:
  - The pointer advances only on response completion.
  - A continuously requesting client waits at most NUM_REQ-1 other transactions.
- busy = (state != IDLE).
- req_ready is never asserted outside IDLE, and never to a requester whose req_valid=0.

Test Plan:
- Reset defaults: assert RST mid-RESP (resp_valid=1) -> all outputs 0 immediately and asynchronously, state IDLE; after release with req_valid=0000, nothing is granted.
- Single request: requester 2 with A=16'hF0F0, B=16'h0FF0, OP=00, resp_ready=1 -> req_ready=0100 in cycle 0, alu_enable=1 in cycle 1 only, resp_valid in cycle 3 with resp_data=16'h00F0, resp_id=2, resp_err=0, ops_done=1.
- Round-robin: req_valid=1111 held, unit models all four ops -> grant order 0,1,2,3,0; each resp_id matches, and no requester is granted twice before the others.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid/data/id stable, no new req_ready, busy=1; resp_ready=1 -> IDLE next cycle.
- Error path: unit model returns alu_flag=0 with OP=11, A=B=16'h0000 -> resp_err=1; resp_data equals the unit output (16'hFFFF from the model); ops_done still increments.
- Saturation/withdraw: preload ops_done to 16'hFFFF via 65535 transactions (or forced) -> the next completion stays at 16'hFFFF; requester 1 drops req_valid before its turn -> it is skipped, no grant.
